branch_resolve_ctrl: RTL and testbench

//  Receiver for branch-unit resolution results (res_valid/prsuccess/prmiss/jmpaddr).

---
 rtl/branch_resolve_ctrl_if.sv | 55 +++++
 rtl/branch_resolve_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of all non-clock/reset signals of branch_resolve_ctrl.
// slave = the controller, master = branch unit / front end side. BRRES_STATS_EN adds counters.
interface branch_resolve_ctrl_if #(
    parameter int SPECTAG_LEN = 5,
    parameter int ADDR_LEN    = 32
);
    logic                   tag_alloc_req;
    logic                   tag_alloc_rdy;
    logic [SPECTAG_LEN-1:0] tag_alloc;
    logic                   res_valid;
    logic                   res_miss;
    logic [SPECTAG_LEN-1:0] res_spectag;
    logic [ADDR_LEN-1:0]    res_pc;
    logic                   res_taken;
    logic [ADDR_LEN-1:0]    res_jmpaddr;
    logic [ADDR_LEN-1:0]    res_target;
    logic [SPECTAG_LEN-1:0] tag_release;
    logic                   kill_valid;
    logic [SPECTAG_LEN-1:0] kill_mask;
    logic                   redirect_valid;
    logic [ADDR_LEN-1:0]    redirect_addr;
    logic                   redirect_ready;
    logic                   upd_valid;
    logic                   upd_ready;
    logic [ADDR_LEN-1:0]    upd_pc;
    logic                   upd_taken;
    logic [ADDR_LEN-1:0]    upd_target;
    logic                   upd_drop;
`ifdef BRRES_STATS_EN
    logic [31:0]            stat_resolved;
    logic [31:0]            stat_mispred;
`endif

    modport slave (
        input  tag_alloc_req, res_valid, res_miss, res_spectag, res_pc, res_taken,
               res_jmpaddr, res_target, redirect_ready, upd_ready,
        output tag_alloc_rdy, tag_alloc, tag_release, kill_valid, kill_mask,
               redirect_valid, redirect_addr, upd_valid, upd_pc, upd_taken,
               upd_target, upd_drop
`ifdef BRRES_STATS_EN
        , output stat_resolved, stat_mispred
`endif
    );

    modport master (
        output tag_alloc_req, res_valid, res_miss, res_spectag, res_pc, res_taken,
               res_jmpaddr, res_target, redirect_ready, upd_ready,
        input  tag_alloc_rdy, tag_alloc, tag_release, kill_valid, kill_mask,
               redirect_valid, redirect_addr, upd_valid, upd_pc, upd_taken,
               upd_target, upd_drop
`ifdef BRRES_STATS_EN
        , input stat_resolved, stat_mispred
`endif
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution receiver: one-hot spec-tag allocator, squash masks, fetch redirect
// and predictor-update FIFO. Optional BRRES_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_ctrl #(
    parameter int SPECTAG_LEN = 5,
    parameter int ADDR_LEN    = 32,
    parameter int UPDQ_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(UPDQ_DEPTH);
    localparam int REC_W = 2 * ADDR_LEN + 1;

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t                 state_reg;
    logic [SPECTAG_LEN-1:0] live_mask_reg, live_mask_next;
    logic [SPECTAG_LEN-1:0] alloc_ptr_reg;
    logic                   ready_en_reg;
    logic [SPECTAG_LEN-1:0] tag_release_reg;
    logic                   kill_valid_reg;
    logic [SPECTAG_LEN-1:0] kill_mask_reg;
    logic [ADDR_LEN-1:0]    redirect_addr_reg;
    logic                   upd_drop_reg;
    logic [PTR_W:0]         wr_ptr_reg, rd_ptr_reg;
    logic [REC_W-1:0]       upd_mem [UPDQ_DEPTH];

    logic                   res_hit, miss_accept, succ_accept, alloc_fire, alloc_rdy;
    logic [SPECTAG_LEN-1:0] tag_next, ptr_rot, range_mask, younger, cursor;
    logic                   stop;
    logic                   fifo_empty, fifo_full, push_ok, pop;
    logic [REC_W-1:0]       head_rec;

    genvar gi;
    generate
        for (gi = 0; gi < SPECTAG_LEN; gi++) begin : g_rot
            assign tag_next[gi] = bus.res_spectag[(gi + SPECTAG_LEN - 1) % SPECTAG_LEN];
            assign ptr_rot[gi]  = alloc_ptr_reg[(gi + SPECTAG_LEN - 1) % SPECTAG_LEN];
        end
    endgenerate

    assign res_hit     = bus.res_valid & (|(bus.res_spectag & live_mask_reg));
    assign miss_accept = res_hit & bus.res_miss;
    assign succ_accept = res_hit & ~bus.res_miss;
    // A miss flushes fetch, so any allocation requested alongside it is refused.
    assign alloc_rdy   = ready_en_reg & (state_reg == IDLE)
                       & ~(|(live_mask_reg & alloc_ptr_reg)) & ~miss_accept;
    assign alloc_fire  = bus.tag_alloc_req & alloc_rdy;

    // Walk from the tag after the missed branch up to (not including) the allocation pointer.
    always_comb begin
        range_mask = '0;
        cursor     = tag_next;
        stop       = 1'b0;
        for (int k = 0; k < SPECTAG_LEN; k++) begin
            if (|(cursor & alloc_ptr_reg)) stop = 1'b1;
            if (!stop) range_mask = range_mask | cursor;
            cursor = {cursor[SPECTAG_LEN-2:0], cursor[SPECTAG_LEN-1]};
        end
    end
    assign younger = range_mask & live_mask_reg;

    always_comb begin
        live_mask_next = live_mask_reg;
        if (miss_accept)
            live_mask_next = live_mask_reg & ~(younger | bus.res_spectag);
        else begin
            if (succ_accept) live_mask_next = live_mask_next & ~bus.res_spectag;
            if (alloc_fire)  live_mask_next = live_mask_next | alloc_ptr_reg;
        end
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W])
                      & (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign pop        = ~fifo_empty & bus.upd_ready;
    assign push_ok    = res_hit & (~fifo_full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            live_mask_reg     <= '0;
            alloc_ptr_reg     <= SPECTAG_LEN'(1);
            ready_en_reg      <= 1'b0;
            tag_release_reg   <= '0;
            kill_valid_reg    <= 1'b0;
            kill_mask_reg     <= '0;
            redirect_addr_reg <= '0;
            upd_drop_reg      <= 1'b0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
        end else begin
            ready_en_reg    <= 1'b1;
            live_mask_reg   <= live_mask_next;
            tag_release_reg <= res_hit ? bus.res_spectag : '0;
            kill_valid_reg  <= miss_accept;
            kill_mask_reg   <= miss_accept ? younger : '0;
            upd_drop_reg    <= res_hit & ~push_ok;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (miss_accept) begin
                // Any live miss here is older than the one being redirected, so it wins.
                state_reg         <= REDIRECT;
                alloc_ptr_reg     <= tag_next;
                redirect_addr_reg <= bus.res_jmpaddr;
            end else begin
                if (alloc_fire) alloc_ptr_reg <= ptr_rot;
                case (state_reg)
                    IDLE:     state_reg <= IDLE;
                    REDIRECT: if (bus.redirect_ready) state_reg <= IDLE;
                    default:  state_reg <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            upd_mem[wr_ptr_reg[PTR_W-1:0]] <= {bus.res_pc, bus.res_taken, bus.res_target};
    end

    assign head_rec = fifo_empty ? '0 : upd_mem[rd_ptr_reg[PTR_W-1:0]];

    assign bus.tag_alloc_rdy  = alloc_rdy;
    assign bus.tag_alloc      = ready_en_reg ? alloc_ptr_reg : '0;
    assign bus.tag_release    = tag_release_reg;
    assign bus.kill_valid     = kill_valid_reg;
    assign bus.kill_mask      = kill_mask_reg;
    assign bus.redirect_valid = (state_reg == REDIRECT);
    assign bus.redirect_addr  = redirect_addr_reg;
    assign bus.upd_valid      = ~fifo_empty;
    assign bus.upd_pc         = head_rec[REC_W-1 -: ADDR_LEN];
    assign bus.upd_taken      = head_rec[ADDR_LEN];
    assign bus.upd_target     = head_rec[ADDR_LEN-1:0];
    assign bus.upd_drop       = upd_drop_reg;

`ifdef BRRES_STATS_EN
    logic [31:0] stat_resolved_reg, stat_mispred_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_resolved_reg <= '0;
            stat_mispred_reg  <= '0;
        end else begin
            if (res_hit && stat_resolved_reg != 32'hFFFF_FFFF)
                stat_resolved_reg <= stat_resolved_reg + 32'd1;
            if (miss_accept && stat_mispred_reg != 32'hFFFF_FFFF)
                stat_mispred_reg <= stat_mispred_reg + 32'd1;
        end
    end
    assign bus.stat_resolved = stat_resolved_reg;
    assign bus.stat_mispred  = stat_mispred_reg;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus a scoreboard
// of predictor-update records compared as they leave the update FIFO.
module tb_branch_resolve_ctrl;
    logic clk;
    logic reset;

    branch_resolve_ctrl_if #(.SPECTAG_LEN(5), .ADDR_LEN(32)) bus ();

    branch_resolve_ctrl #(.SPECTAG_LEN(5), .ADDR_LEN(32), .UPDQ_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } rec_t;

    rec_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: a pop happens at the next rising edge whenever valid&ready.
    always @(negedge clk) begin
        if (reset && bus.upd_valid && bus.upd_ready) begin
            check("upd_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                rec_t r;
                r = sb.pop_front();
                $display("[TB] upd pop pc=%0h taken=%0b target=%0h", bus.upd_pc, bus.upd_taken, bus.upd_target);
                check("upd_pc", 64'(bus.upd_pc), 64'(r.pc));
                check("upd_taken", 64'(bus.upd_taken), 64'(r.taken));
                check("upd_target", 64'(bus.upd_target), 64'(r.target));
            end
        end
    end

    task automatic alloc(input logic [4:0] exp_tag);
        bus.tag_alloc_req = 1'b1;
        $display("[TB] alloc expect tag=%02h", exp_tag);
        check("alloc_rdy", 64'(bus.tag_alloc_rdy), 64'd1);
        check("alloc_tag", 64'(bus.tag_alloc), 64'(exp_tag));
        tick();
        bus.tag_alloc_req = 1'b0;
    endtask

    task automatic resolve(input logic [4:0] tag, input logic miss, input logic [31:0] pc,
                           input logic taken, input logic [31:0] jmp, input logic [31:0] target,
                           input bit exp_push);
        rec_t r;
        bus.res_valid   = 1'b1;
        bus.res_spectag = tag;
        bus.res_miss    = miss;
        bus.res_pc      = pc;
        bus.res_taken   = taken;
        bus.res_jmpaddr = jmp;
        bus.res_target  = target;
        $display("[TB] resolve tag=%02h miss=%0b pc=%0h jmp=%0h push=%0b", tag, miss, pc, jmp, exp_push);
        if (exp_push) begin
            r = '{pc: pc, taken: taken, target: target};
            sb.push_back(r);
        end
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        repeat (3) tick();
        reset = 1'b0;
        #1;
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        $display("[TB] reset pulse done");
    endtask

    initial begin
        reset              = 1'b1;
        bus.tag_alloc_req  = 1'b0;
        bus.res_valid      = 1'b0;
        bus.res_miss       = 1'b0;
        bus.res_spectag    = '0;
        bus.res_pc         = '0;
        bus.res_taken      = 1'b0;
        bus.res_jmpaddr    = '0;
        bus.res_target     = '0;
        bus.redirect_ready = 1'b0;
        bus.upd_ready      = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_rdy", 64'(bus.tag_alloc_rdy), 64'd0);
        check("rst_redirect", 64'(bus.redirect_valid), 64'd0);
        check("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
        check("rst_kill", 64'(bus.kill_valid), 64'd0);
        reset = 1'b1;
        #1;
        check("rdy_before_edge", 64'(bus.tag_alloc_rdy), 64'd0);
        tick();
        check("rdy_after_release", 64'(bus.tag_alloc_rdy), 64'd1);

        // Five allocations fill every tag.
        for (int i = 0; i < 5; i++) alloc(5'(1 << i));
        check("all_live_rdy", 64'(bus.tag_alloc_rdy), 64'd0);

        // Miss on 02 with 01..08 live and pointer at 10.
        reset_pulse();
        for (int i = 0; i < 4; i++) alloc(5'(1 << i));
        resolve(5'h02, 1'b1, 32'h40, 1'b1, 32'h100, 32'h100, 1'b1);
        check("miss_kill_valid", 64'(bus.kill_valid), 64'd1);
        check("miss_kill_mask", 64'(bus.kill_mask), 64'h0C);
        check("miss_release", 64'(bus.tag_release), 64'h02);
        check("miss_redirect_valid", 64'(bus.redirect_valid), 64'd1);
        check("redirect_blocks_alloc", 64'(bus.tag_alloc_rdy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("redirect_hold_valid", 64'(bus.redirect_valid), 64'd1);
            check("redirect_hold_addr", 64'(bus.redirect_addr), 64'h100);
            tick();
        end
        check("kill_is_pulse", 64'(bus.kill_valid), 64'd0);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        check("redirect_done", 64'(bus.redirect_valid), 64'd0);
        alloc(5'h04);

        // Success on 04 releases it for exactly one cycle.
        resolve(5'h04, 1'b0, 32'h80, 1'b0, 32'h84, 32'h300, 1'b1);
        check("succ_release", 64'(bus.tag_release), 64'h04);
        check("succ_no_kill", 64'(bus.kill_valid), 64'd0);
        tick();
        check("release_pulse", 64'(bus.tag_release), 64'h00);

        // Nested miss: older branch overrides the pending redirect; killed tag is ignored.
        reset_pulse();
        for (int i = 0; i < 4; i++) alloc(5'(1 << i));
        resolve(5'h04, 1'b1, 32'h90, 1'b1, 32'h180, 32'h180, 1'b1);
        check("miss04_kill_mask", 64'(bus.kill_mask), 64'h08);
        check("miss04_addr", 64'(bus.redirect_addr), 64'h180);
        resolve(5'h01, 1'b1, 32'h10, 1'b0, 32'h200, 32'h500, 1'b1);
        check("miss01_kill_valid", 64'(bus.kill_valid), 64'd1);
        check("miss01_kill_mask", 64'(bus.kill_mask), 64'h02);
        check("miss01_addr", 64'(bus.redirect_addr), 64'h200);
        check("miss01_release", 64'(bus.tag_release), 64'h01);
        check("miss01_redirect", 64'(bus.redirect_valid), 64'd1);
        resolve(5'h08, 1'b0, 32'hA0, 1'b1, 32'hA4, 32'h600, 1'b0);
        check("killed_no_release", 64'(bus.tag_release), 64'h00);
        check("killed_no_kill", 64'(bus.kill_valid), 64'd0);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        check("nested_redirect_done", 64'(bus.redirect_valid), 64'd0);
        alloc(5'h02);

        // FIFO overflow with the consumer stalled, then push and pop on a full FIFO.
        reset_pulse();
        bus.upd_ready = 1'b0;
        for (int i = 0; i < 5; i++) alloc(5'(1 << i));
        for (int i = 0; i < 4; i++) begin
            resolve(5'(1 << i), 1'b0, 32'h1000 + 32'(i * 4), i[0], 32'h0, 32'h2000 + 32'(i), 1'b1);
            check("no_drop", 64'(bus.upd_drop), 64'd0);
        end
        resolve(5'h10, 1'b0, 32'h1010, 1'b1, 32'h0, 32'h2004, 1'b0);
        check("full_drop", 64'(bus.upd_drop), 64'd1);
        check("full_valid", 64'(bus.upd_valid), 64'd1);
        tick();
        check("drop_pulse", 64'(bus.upd_drop), 64'd0);
        alloc(5'h01);
        bus.upd_ready = 1'b1;
        resolve(5'h01, 1'b0, 32'h3000, 1'b1, 32'h0, 32'h3100, 1'b1);
        check("full_push_pop", 64'(bus.upd_drop), 64'd0);

        // Asynchronous reset while a redirect and an update record are pending.
        reset_pulse();
        bus.upd_ready = 1'b0;
        alloc(5'h01);
        resolve(5'h01, 1'b1, 32'h50, 1'b1, 32'h300, 32'h300, 1'b1);
        check("pre_rst_redirect", 64'(bus.redirect_valid), 64'd1);
        check("pre_rst_upd_valid", 64'(bus.upd_valid), 64'd1);
        reset = 1'b0;
        #1;
        sb.delete();
        check("async_redirect", 64'(bus.redirect_valid), 64'd0);
        check("async_upd_valid", 64'(bus.upd_valid), 64'd0);
        check("async_release", 64'(bus.tag_release), 64'h00);
        check("async_rdy", 64'(bus.tag_alloc_rdy), 64'd0);
        tick();
        reset = 1'b1;
        bus.upd_ready = 1'b1;
        tick();
        check("post_rst_rdy", 64'(bus.tag_alloc_rdy), 64'd1);
        check("post_rst_tag", 64'(bus.tag_alloc), 64'h01);
        check("post_rst_upd_valid", 64'(bus.upd_valid), 64'd0);

        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
